// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator hall-call panel: floor count default,
// call-FSM encoding and pending-count width.
package elevator_pkg;
  localparam int unsigned FLOORS_DEFAULT = 3;
  localparam int unsigned PEND_W         = 2;

  typedef enum logic [1:0] {
    CALL_IDLE  = 2'b00,
    CALL_ISSUE = 2'b01,
    CALL_WAIT  = 2'b10
  } call_state_t;
endpackage

// File: rtl/elevator_call_panel_if.sv
// B/R call interface between the hall-call panel (master) and the elevator
// controller (slave), together with the raw buttons, lamps and pending count.
interface elevator_call_panel_if
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS = FLOORS_DEFAULT
);
  logic [FLOORS:1]   BTN;
  logic [FLOORS:1]   R;
  logic [FLOORS:1]   B;
  logic [FLOORS:1]   LAMP;
  logic [PEND_W-1:0] PEND;

  modport master (input BTN, input R, output B, output LAMP, output PEND);
  modport slave  (output BTN, output R, input B, input LAMP, input PEND);
endinterface

// File: rtl/elevator_call_panel_call_debounce.sv
// Per-floor button conditioner: 2-flop synchroniser plus optional debounce
// filter (enabled by ELEV_DEBOUNCE_EN), producing the filtered level F.
module call_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  output logic F
);
  logic       sync1;
  logic       sync2;
  logic       f_raw;
  logic       armed;
  logic [1:0] vld;

  if (DB_CYCLES < 1 || DB_CYCLES > 7) begin : g_bad_db
    $error("call_debounce: DB_CYCLES must be 1..7");
  end

  // armed blocks a button held through reset until it has been seen released
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      vld   <= 2'd0;
      armed <= 1'b0;
    end else begin
      sync1 <= BTN;
      sync2 <= sync1;
      vld   <= (vld == 2'd2) ? vld : vld + 2'd1;
      armed <= armed | ((vld == 2'd2) && !sync2 && !f_raw);
    end
  end

`ifdef ELEV_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      f_raw <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == f_raw) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
      f_raw <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  assign f_raw = sync2;
`endif

  assign F = f_raw & armed;
endmodule

// File: rtl/elevator_call_panel.sv
// Hall-call front end: per-floor call FSMs issuing one-cycle B requests and
// holding lamps until R. Debounce optional via ELEV_DEBOUNCE_EN.
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS    = FLOORS_DEFAULT,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  elevator_call_panel_if.master bus
);
  logic [FLOORS:1]   f;
  logic [FLOORS:1]   f_q;
  logic [FLOORS:1]   press;
  logic [FLOORS:1]   b_nxt;
  logic [FLOORS:1]   lamp_nxt;
  logic [PEND_W-1:0] pend_nxt;
  call_state_t       st     [FLOORS:1];
  call_state_t       st_nxt [FLOORS:1];

  for (genvar g = 1; g <= FLOORS; g++) begin : g_floor
    call_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .CLK   (CLK),
      .RST_N (RST_N),
      .BTN   (bus.BTN[g]),
      .F     (f[g])
    );
  end

  assign press = f & ~f_q;

  // next state per floor; outputs and pending count follow the next state
  always_comb begin
    pend_nxt = '0;
    b_nxt    = '0;
    lamp_nxt = '0;
    for (int n = 1; n <= int'(FLOORS); n++) begin
      st_nxt[n] = st[n];
      case (st[n])
        CALL_IDLE:  if (press[n] && !bus.R[n]) st_nxt[n] = CALL_ISSUE;
        CALL_ISSUE: st_nxt[n] = bus.R[n] ? CALL_IDLE : CALL_WAIT;
        CALL_WAIT:  if (bus.R[n]) st_nxt[n] = CALL_IDLE;
        default:    st_nxt[n] = CALL_IDLE;
      endcase
      b_nxt[n]    = (st_nxt[n] == CALL_ISSUE);
      lamp_nxt[n] = (st_nxt[n] != CALL_IDLE);
      if (lamp_nxt[n]) pend_nxt = pend_nxt + PEND_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st       <= '{default: CALL_IDLE};
      f_q      <= '0;
      bus.B    <= '0;
      bus.LAMP <= '0;
      bus.PEND <= '0;
    end else begin
      st       <= st_nxt;
      f_q      <= f;
      bus.B    <= b_nxt;
      bus.LAMP <= lamp_nxt;
      bus.PEND <= pend_nxt;
    end
  end
endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed self-checking bench for elevator_call_panel (FLOORS=3, DB_CYCLES=4).
module tb_elevator_call_panel;
  localparam int unsigned DB = 4;
`ifdef ELEV_DEBOUNCE_EN
  localparam int PL  = 3 + DB;
  localparam bit DBE = 1'b1;
`else
  localparam int PL  = 3;
  localparam bit DBE = 1'b0;
`endif

  logic CLK;
  logic RST_N;
  int   vectors;
  int   miscompares;
  int   pcnt [1:3];

  elevator_call_panel_if #(.FLOORS(3)) bus ();

  elevator_call_panel #(.FLOORS(3), .DB_CYCLES(DB)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    for (int n = 1; n <= 3; n++) if (bus.B[n] === 1'b1) pcnt[n]++;
  endtask

  task automatic ticks(input int cnt);
    repeat (cnt) tick();
  endtask

  task automatic clr();
    pcnt = '{0, 0, 0};
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clr();
    RST_N   = 1'b0;
    bus.BTN = 3'b000;
    bus.R   = 3'b000;
    ticks(3);
    chk("rst_b", 32'(bus.B), 32'h0);
    chk("rst_lamp", 32'(bus.LAMP), 32'h0);
    chk("rst_pend", 32'(bus.PEND), 32'h0);
    RST_N = 1'b1;
    ticks(4);

    // single call on floor 2
    clr();
    bus.BTN = 3'b010;
    ticks(PL - 1);
    chk("single_early", 32'(bus.B), 32'h0);
    tick();
    chk("single_b", 32'(bus.B), 32'h2);
    chk("single_pend", 32'(bus.PEND), 32'h1);
    tick();
    chk("single_b_drop", 32'(bus.B), 32'h0);
    chk("single_lamp", 32'(bus.LAMP), 32'h2);
    ticks(20 - PL - 1);
    chk("single_count", 32'(pcnt[2]), 32'h1);
    bus.BTN = 3'b000;
    bus.R   = 3'b010;
    tick();
    bus.R = 3'b000;
    chk("serve2_lamp", 32'(bus.LAMP), 32'h0);
    chk("serve2_pend", 32'(bus.PEND), 32'h0);
    ticks(10);

    // bounce on floor 1, then stable press
    clr();
    for (int i = 0; i < 4; i++) begin
      bus.BTN = 3'b001;
      ticks(2);
      bus.BTN = 3'b000;
      ticks(2);
    end
    chk("bounce_count", 32'(pcnt[1]), DBE ? 32'h0 : 32'h1);
    clr();
    bus.BTN = 3'b001;
    ticks(PL + 2);
    chk("stable_count", 32'(pcnt[1]), DBE ? 32'h1 : 32'h0);
    chk("stable_lamp", 32'(bus.LAMP), 32'h1);
    bus.R = 3'b001;
    tick();
    bus.R   = 3'b000;
    bus.BTN = 3'b000;
    chk("serve1_lamp", 32'(bus.LAMP), 32'h0);
    ticks(10);

    // press at the car's floor is discarded
    clr();
    bus.R   = 3'b100;
    bus.BTN = 3'b100;
    ticks(PL + 4);
    chk("carfloor_count", 32'(pcnt[3]), 32'h0);
    chk("carfloor_lamp", 32'(bus.LAMP), 32'h0);
    bus.BTN = 3'b000;
    ticks(10);
    bus.R = 3'b000;
    tick();

    // R arrives during ISSUE
    bus.BTN = 3'b100;
    ticks(PL - 1);
    chk("issueR_early", 32'(bus.B), 32'h0);
    tick();
    chk("issueR_b", 32'(bus.B), 32'h4);
    bus.R = 3'b100;
    tick();
    bus.R = 3'b000;
    chk("issueR_lamp", 32'(bus.LAMP), 32'h0);
    chk("issueR_pend", 32'(bus.PEND), 32'h0);
    bus.BTN = 3'b000;
    ticks(10);

    // simultaneous calls
    clr();
    bus.BTN = 3'b111;
    ticks(PL);
    chk("simul_b", 32'(bus.B), 32'h7);
    chk("simul_pend", 32'(bus.PEND), 32'h3);
    tick();
    chk("simul_b_drop", 32'(bus.B), 32'h0);
    chk("simul_lamp", 32'(bus.LAMP), 32'h7);
    bus.R = 3'b010;
    tick();
    bus.R = 3'b000;
    chk("simul_pend2", 32'(bus.PEND), 32'h2);
    chk("simul_lamp2", 32'(bus.LAMP), 32'h5);

    // repeat press on floor 1 while pending
    bus.BTN = 3'b000;
    ticks(10);
    clr();
    bus.BTN = 3'b001;
    ticks(PL + 4);
    chk("repeat_count", 32'(pcnt[1]), 32'h0);
    chk("repeat_pend", 32'(bus.PEND), 32'h2);
    bus.R = 3'b001;
    tick();
    bus.R = 3'b000;
    chk("simul_pend1", 32'(bus.PEND), 32'h1);
    chk("simul_lamp1", 32'(bus.LAMP), 32'h4);
    bus.R = 3'b100;
    tick();
    bus.R = 3'b000;
    chk("simul_pend0", 32'(bus.PEND), 32'h0);

    // reset mid-call with buttons held
    bus.BTN = 3'b000;
    ticks(10);
    bus.BTN = 3'b111;
    ticks(PL + 2);
    chk("prerst_pend", 32'(bus.PEND), 32'h3);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_lamp", 32'(bus.LAMP), 32'h0);
    chk("midrst_pend", 32'(bus.PEND), 32'h0);
    chk("midrst_b", 32'(bus.B), 32'h0);
    ticks(3);
    RST_N = 1'b1;
    clr();
    ticks(PL + 8);
    chk("held_count", 32'(pcnt[1] + pcnt[2] + pcnt[3]), 32'h0);
    chk("held_lamp", 32'(bus.LAMP), 32'h0);
    bus.BTN = 3'b000;
    ticks(12);
    clr();
    bus.BTN = 3'b111;
    ticks(PL);
    chk("rearm_b", 32'(bus.B), 32'h7);
    tick();
    chk("rearm_count", 32'(pcnt[1] + pcnt[2] + pcnt[3]), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
